// File: rtl/pwr_regulator.sv
// pwr_regulator: multi-channel closed-loop duty regulator.
// Each channel compares its latest power sample against a shared target window
// and nudges its PWM duty by a saturated step once per divided update tick.
module pwr_regulator #(
  parameter int unsigned CH        = 4,
  parameter int unsigned PWR_W     = 8,
  parameter int unsigned DUTY_W    = 7,
  parameter int unsigned DUTY_INIT = 29,
  parameter int unsigned DUTY_MIN  = 0,
  parameter int unsigned DUTY_MAX  = 127,
  parameter int unsigned STEP      = 1,
  parameter int unsigned DIV       = 16,
  parameter int unsigned LOCK_N    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [PWR_W-1:0]     target,
  input  logic [PWR_W-1:0]     band,
  input  logic [CH*PWR_W-1:0]  curr_pwr,
  input  logic [CH-1:0]        pwr_valid,
  output logic [CH*DUTY_W-1:0] duty,
  output logic [CH-1:0]        at_min,
  output logic [CH-1:0]        at_max,
  output logic [CH-1:0]        locked
);

  localparam int unsigned DW1   = DUTY_W + 1;
  localparam int unsigned PW1   = PWR_W + 1;
  localparam int unsigned LCK_W = 4;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0]  r_div;
  logic [PWR_W-1:0]  r_sample [CH];
  logic [CH-1:0]     r_fresh;
  logic [DUTY_W-1:0] r_duty   [CH];
  logic [LCK_W-1:0]  r_lock   [CH];

  logic              w_tick;
  logic [PW1-1:0]    w_lo_ext;
  logic [PW1-1:0]    w_hi_ext;
  logic [PWR_W-1:0]  w_lo;
  logic [PWR_W-1:0]  w_hi;
  logic [CH-1:0]     w_below;
  logic [CH-1:0]     w_above;
  logic [DW1-1:0]    w_dn_ext [CH];
  logic [DW1-1:0]    w_up_ext [CH];
  logic [DUTY_W-1:0] w_dn_sat [CH];
  logic [DUTY_W-1:0] w_up_sat [CH];
  logic [LCK_W-1:0]  w_lock_inc [CH];

  assign w_tick = en && (r_div == DIV_W'(DIV - 1));

  // Update-rate divider: free-runs while enabled, parked at zero otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (!en || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Target window bounds, saturated to the sample range via the carry/borrow bit
  always_comb begin
    w_lo_ext = {1'b0, target} - {1'b0, band};
    w_hi_ext = {1'b0, target} + {1'b0, band};
    w_lo     = w_lo_ext[PWR_W] ? '0 : w_lo_ext[PWR_W-1:0];
    w_hi     = w_hi_ext[PWR_W] ? '1 : w_hi_ext[PWR_W-1:0];
  end

  // Per-channel window compare and clamped duty / lock candidates
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_below[i]    = r_sample[i] < w_lo;
      w_above[i]    = r_sample[i] > w_hi;
      w_dn_ext[i]   = DW1'(r_duty[i]) - DW1'(STEP);
      w_up_ext[i]   = DW1'(r_duty[i]) + DW1'(STEP);
      w_dn_sat[i]   = (DW1'(r_duty[i]) < DW1'(DUTY_MIN) + DW1'(STEP)) ?
                      DUTY_W'(DUTY_MIN) : DUTY_W'(w_dn_ext[i]);
      w_up_sat[i]   = (w_up_ext[i] > DW1'(DUTY_MAX)) ?
                      DUTY_W'(DUTY_MAX) : DUTY_W'(w_up_ext[i]);
      w_lock_inc[i] = (r_lock[i] >= LCK_W'(LOCK_N)) ?
                      LCK_W'(LOCK_N) : r_lock[i] + LCK_W'(1);
    end
  end

  // Sample capture; a coincident tick consumes the old sample, the new one stays fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fresh <= '0;
      for (int i = 0; i < CH; i++) begin
        r_sample[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (pwr_valid[i]) begin
          r_sample[i] <= curr_pwr[i*PWR_W +: PWR_W];
          r_fresh[i]  <= 1'b1;
        end else if (w_tick) begin
          r_fresh[i]  <= 1'b0;
        end
      end
    end
  end

  // Duty regulation and lock counting, only on ticks with a fresh sample
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        r_duty[i] <= DUTY_W'(DUTY_INIT);
        r_lock[i] <= '0;
      end
    end else if (w_tick) begin
      for (int i = 0; i < CH; i++) begin
        if (r_fresh[i]) begin
          if (w_below[i]) begin
            r_duty[i] <= w_dn_sat[i];
            r_lock[i] <= '0;
          end else if (w_above[i]) begin
            r_duty[i] <= w_up_sat[i];
            r_lock[i] <= '0;
          end else begin
            r_lock[i] <= w_lock_inc[i];
          end
        end
      end
    end
  end

  // Output packing and status decode straight from registers
  always_comb begin
    duty = '0;
    for (int i = 0; i < CH; i++) begin
      duty[i*DUTY_W +: DUTY_W] = r_duty[i];
      at_min[i] = r_duty[i] == DUTY_W'(DUTY_MIN);
      at_max[i] = r_duty[i] == DUTY_W'(DUTY_MAX);
      locked[i] = r_lock[i] == LCK_W'(LOCK_N);
    end
  end

endmodule

// File: doc/pwr_regulator.md
# pwr_regulator

Multi-channel closed-loop duty regulator: per channel, compares a measured power sample against a programmable target window and steps that channel's PWM duty down (power low) or up (power high) at a divided update rate. Each update applies a saturated step, and lock/limit status flags are kept per channel. It sits between the power-measurement ADC front end and the per-channel PWM generators, replacing the single-channel fixed-threshold controller.

## Interface
- CH, 4: number of independent channels
- PWR_W, 8: power sample width
- DUTY_W, 7: duty word width
- DUTY_INIT, 29: duty value after reset
- DUTY_MIN, 0 / DUTY_MAX, 127: duty clamp limits (DUTY_MIN ≤ DUTY_INIT ≤ DUTY_MAX < 2^DUTY_W)
- STEP, 1: duty increment/decrement per update
- DIV, 16: clocks per update tick (≥2)
- LOCK_N, 4: consecutive in-window updates required for lock (1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  regulation enable; low freezes all duties
- target  in  PWR_W  window centre, shared by all channels
- band  in  PWR_W  window half-width
- curr_pwr  in  CH*PWR_W  packed samples, channel i at [i*PWR_W +: PWR_W]
- pwr_valid  in  CH  per-channel sample strobe
- duty  out  CH*DUTY_W  packed duty, channel i at [i*DUTY_W +: DUTY_W]
- at_min  out  CH  duty == DUTY_MIN
- at_max  out  CH  duty == DUTY_MAX
- locked  out  CH  channel settled inside window

## Operation
- Sample capture: on a clock with pwr_valid[i]=1, the sample register for channel i loads curr_pwr slice i and fresh[i] is set. Capture is independent of en.
- Divider: a counter runs 0..DIV-1 while en=1 and wraps. tick=1 in the cycle the count equals DIV-1. With en=0 the counter is held at 0 and no tick occurs.
- Window: lo = target − band, saturating at 0; hi = target + band, saturating at 2^PWR_W−1. Both are computed with PWR_W+1 bits internally. A sample s is in-window when lo ≤ s ≤ hi. Example: target 193, band 1 gives window 192..194.
- On tick, for each channel with fresh[i]=1, using the stored sample:
  - s < lo: duty ← max(duty − STEP, DUTY_MIN); lock counter ← 0.
  - s > hi: duty ← min(duty + STEP, DUTY_MAX); lock counter ← 0.
  - in-window: duty unchanged; lock counter ← min(count+1, LOCK_N).
  - fresh[i] is cleared.
- Channels with fresh[i]=0 at tick keep duty and lock counter unchanged (stale data is never acted on twice).
- Simultaneous tick and pwr_valid[i]: the decision uses the previously stored sample. The new sample is stored and fresh[i] remains 1 for the next tick.
- Clamp arithmetic uses DUTY_W+1 bits, so no wrap-around is possible at either limit.
- locked[i] = (lock counter == LOCK_N). at_min and at_max are decoded from the registered duty.

## Timing
- Reset (synchronous): duty = DUTY_INIT on all channels, sample regs = 0, fresh = 0, divider = 0, lock counters = 0. Consequently locked = 0, and at_min/at_max reflect DUTY_INIT vs the limits.
- Reset asserted mid-operation takes effect at the next edge and overrides tick and pwr_valid in the same cycle.
- Latency: the duty change is visible on the edge that ends the tick cycle. locked rises on the same edge as the LOCK_N-th in-window update.
- The first tick after reset or after en rises occurs DIV clocks after en=1 is sampled.
- en falling in a tick cycle: no update happens that cycle.
- All outputs are registered or decoded directly from registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset defaults: assert reset 2 clocks -> every duty slice = 29, at_min = at_max = locked = 0.
- Low power, DIV=16, target 193, band 1: ch0 sample 150 presented once per tick -> duty0 steps 29, 28, … one per 16 clocks, clamps at 0 with at_min0 = 1 and never wraps to 127.
- High power: ch1 sample 200 repeated -> duty1 rises to 127 and holds, at_max1 = 1. An isolated sample of 194 produces no change.
- Lock: ch2 samples 193 every tick -> locked2 = 1 after the 4th update. One sample of 191 then clears locked2 and decrements duty2 by 1.
- Stale/coincident: no pwr_valid for 3 ticks -> duty unchanged. pwr_valid coinciding with tick -> old sample acted on, new sample acted on at the next tick.
- Window saturation and control: target 2, band 5 -> lo = 0, so sample 0 counts as in-window. en=0 for 100 clocks -> duties frozen. Reset mid-ramp -> duty returns to 29.
